// File: rtl/ir_fetch.sv
// ir_fetch: instruction fetch sequencer, the writer side of the instruction register.
// On a fetch request it reads the word at IC over the memory bus and presents it to IR.
// It then strobes the IR load and pulses the IC increment.
// In user mode it flags privileged opcodes with IR invalidate plus an illegal-instruction
// interrupt request.
//
// Ports:
//   clk      in   1   clock, rising edge
//   _rst     in   1   asynchronous reset, active low
//   fetch    in   1   fetch request, accepted in IDLE only
//   abort    in   1   synchronous abort, returns to IDLE from any state
//   q        in   1   user mode, sampled in CHECK
//   ic       in  16   instruction counter, captured when the request is accepted
//   mem_ad   out 16   memory address, stable for the whole memory cycle
//   mem_rd   out  1   memory read request (level)
//   mem_ok   in   1   memory answer, data valid in the same cycle
//   mem_d    in  16   memory read data
//   ir_d     out 16   word for the IR data input
//   ir_c     out  1   IR load strobe (pulse)
//   ir_inv   out  1   IR invalidate (pulse)
//   ic_inc   out  1   IC increment request (pulse)
//   illegal  out  1   illegal-instruction interrupt request (pulse)
//   alarm    out  1   memory no-answer alarm (pulse)
//   busy     out  1   high in any state other than IDLE
//   done     out  1   fetch complete (pulse)
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for a fetch request
// REQ    | mem_rd high, waiting for mem_ok or for the answer timeout
// LOAD   | word latched in ir_d; ir_c and ic_inc pulse
// CHECK  | done pulses; privileged word in user mode raises ir_inv/illegal
// ALARM  | memory did not answer; alarm pulses
module ir_fetch #(
  parameter int          TIMEOUT   = 16,
  parameter logic [15:0] PRIV_MASK = 16'hfc00,
  parameter logic [15:0] PRIV_VAL  = 16'hec00
) (
  input  logic        clk,
  input  logic        _rst,
  input  logic        fetch,
  input  logic        abort,
  input  logic        q,
  input  logic [15:0] ic,
  output logic [15:0] mem_ad,
  output logic        mem_rd,
  input  logic        mem_ok,
  input  logic [15:0] mem_d,
  output logic [15:0] ir_d,
  output logic        ir_c,
  output logic        ir_inv,
  output logic        ic_inc,
  output logic        illegal,
  output logic        alarm,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_LOAD  = 3'd2,
    S_CHECK = 3'd3,
    S_ALARM = 3'd4
  } state_t;

  // Last REQ cycle before the answer timeout expires.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       rd_q;
  logic       load_q;
  logic       done_q;
  logic       priv_q;
  logic       alarm_q;

  // Output flags are registered together with the state they belong to,
  // so each one is high for exactly the cycle spent in that state.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state   <= S_IDLE;
      mem_ad  <= 16'h0000;
      ir_d    <= 16'h0000;
      cnt     <= 8'h00;
      rd_q    <= 1'b0;
      load_q  <= 1'b0;
      done_q  <= 1'b0;
      priv_q  <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      rd_q    <= 1'b0;
      load_q  <= 1'b0;
      done_q  <= 1'b0;
      priv_q  <= 1'b0;
      alarm_q <= 1'b0;
      if (abort) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (fetch) begin
              mem_ad <= ic;
              cnt    <= 8'h00;
              rd_q   <= 1'b1;
              state  <= S_REQ;
            end
          end
          S_REQ: begin
            // An answer in the expiry cycle still counts as a normal load.
            if (mem_ok) begin
              ir_d   <= mem_d;
              load_q <= 1'b1;
              state  <= S_LOAD;
            end else if (cnt == CNT_LAST) begin
              alarm_q <= 1'b1;
              state   <= S_ALARM;
            end else begin
              cnt   <= cnt + 8'd1;
              rd_q  <= 1'b1;
            end
          end
          S_LOAD: begin
            done_q <= 1'b1;
            priv_q <= ((ir_d & PRIV_MASK) == PRIV_VAL);
            state  <= S_CHECK;
          end
          S_CHECK: state <= S_IDLE;
          S_ALARM: state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // abort silences everything in the cycle it is asserted, not only from the
  // next state on. User mode is looked at during CHECK itself, so q is
  // combined here rather than at the LOAD->CHECK edge.
  assign mem_rd  = rd_q & ~abort;
  assign ir_c    = load_q & ~abort;
  assign ic_inc  = load_q & ~abort;
  assign done    = done_q & ~abort;
  assign ir_inv  = priv_q & q & ~abort;
  assign illegal = priv_q & q & ~abort;
  assign alarm   = alarm_q & ~abort;
  assign busy    = (state != S_IDLE);

endmodule
